c499_ecc_encoder: RTL

Streaming single-error-correcting check-bit generator producing 40-bit codewords: 32 data bits plus 8 check bits. Its output is what the c499 SEC corrector consumes: data bit i maps to that circuit's input N(1+4i), and check bit j maps to N(129+j), with N137 tied high. The block is a 2-stage valid/ready pipeline with full backpressure. It also provides a codeword counter for bench and status use.

---
 rtl/c499_ecc_encoder_if.sv | 37 +++
 rtl/c499_ecc_encoder.sv | 115 +++++++++++
 2 files changed

// File: rtl/c499_ecc_encoder_if.sv
// Valid/ready stream bundle for the c499 check-bit encoder.
// Optional injection fields exist only when C499_ERR_INJECT_EN is defined.
interface c499_ecc_encoder_if;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CHECK_W = 8;
   localparam int unsigned POS_W   = 6;

   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_data;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic [CHECK_W-1:0] out_check;
`ifdef C499_ERR_INJECT_EN
   logic               inj_en;
   logic [POS_W-1:0]   inj_pos;

   modport master (
      output in_valid, in_data, inj_en, inj_pos, out_ready,
      input  in_ready, out_valid, out_data, out_check
   );
   modport slave (
      input  in_valid, in_data, inj_en, inj_pos, out_ready,
      output in_ready, out_valid, out_data, out_check
   );
`else
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_check
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_check
   );
`endif
endinterface

// File: rtl/c499_ecc_encoder.sv
// Two-stage valid/ready SEC check-bit generator feeding the c499 corrector.
// Optional single-bit error injection is enabled by defining C499_ERR_INJECT_EN.
module c499_ecc_encoder (
   input  logic                clk,
   input  logic                rst,
   c499_ecc_encoder_if.slave   bus,
   output logic [15:0]         word_cnt
);
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CHECK_W = 8;
   localparam int unsigned CW_W    = DATA_W + CHECK_W;
   localparam int unsigned CNT_W   = 16;

   // Each check bit covers 12 data bits; every data bit lands in exactly three.
   function automatic logic [CHECK_W-1:0] gen_check(input logic [DATA_W-1:0] d);
      logic [CHECK_W-1:0] c;
      c[0] = ^{d[0],  d[4],  d[8],  d[12], d[23:16]};
      c[1] = ^{d[1],  d[5],  d[9],  d[13], d[31:24]};
      c[2] = ^{d[2],  d[6],  d[10], d[14], d[19:16], d[27:24]};
      c[3] = ^{d[3],  d[7],  d[11], d[15], d[23:20], d[31:28]};
      c[4] = ^{d[16], d[20], d[24], d[28], d[7:0]};
      c[5] = ^{d[17], d[21], d[25], d[29], d[15:8]};
      c[6] = ^{d[18], d[22], d[26], d[30], d[3:0],   d[11:8]};
      c[7] = ^{d[19], d[23], d[27], d[31], d[7:4],   d[15:12]};
      return c;
   endfunction

   logic                s1_valid;
   logic [DATA_W-1:0]   s1_data;
   logic                s2_valid;
   logic [DATA_W-1:0]   s2_data;
   logic [CHECK_W-1:0]  s2_check;
   logic [CNT_W-1:0]    cnt;

   logic                in_fire;
   logic                out_fire;
   logic                s2_load;
   logic [CW_W-1:0]     flip_c;
   logic [CW_W-1:0]     cw_c;

   assign out_fire     = s2_valid && bus.out_ready;
   assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
   assign bus.in_ready = !s1_valid || s2_load;
   assign in_fire      = bus.in_valid && bus.in_ready;

`ifdef C499_ERR_INJECT_EN
   logic                s1_inj_en;
   logic [5:0]          s1_inj_pos;

   // Injection request travels with its word so it affects that word only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_inj_en  <= 1'b0;
         s1_inj_pos <= 6'd0;
      end else if (in_fire) begin
         s1_inj_en  <= bus.inj_en;
         s1_inj_pos <= bus.inj_pos;
      end
   end

   // Positions 40..63 address nothing and leave the codeword clean.
   always_comb begin
      flip_c = '0;
      if (s1_inj_en && (s1_inj_pos < 6'd40)) begin
         flip_c = CW_W'(1) << s1_inj_pos;
      end
   end
`else
   assign flip_c = '0;
`endif

   assign cw_c = {gen_check(s1_data), s1_data} ^ flip_c;

   // Stage 1: capture the accepted word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_data  <= bus.in_data;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: codeword register driving the outputs directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_check <= '0;
      end else if (s2_load) begin
         s2_valid <= 1'b1;
         s2_data  <= cw_c[DATA_W-1:0];
         s2_check <= cw_c[CW_W-1:DATA_W];
      end else if (out_fire) begin
         s2_valid <= 1'b0;
      end
   end

   // Output transfer counter, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (out_fire) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data;
   assign bus.out_check = s2_check;
   assign word_cnt      = cnt;
endmodule
